mux_arb_n: RTL and testbench

- Parametrised N-channel, W-bit registered multiplexer with per-channel valid/ready handshake.
- Generalises the 4:1 single-bit select mux in three ways: any channel count, any data width, and two selection modes (direct select or round-robin arbitration).
- Sits between several producers and one consumer. It provides one output register stage and backpressure.

---
 rtl/mux_arb_pkg.sv | 20 ++
 rtl/mux_arb_n_if.sv | 35 +++
 rtl/mux_arb_n_rr_arbiter.sv | 45 ++++
 rtl/mux_arb_n.sv | 135 +++++++++++++
 tb/tb_mux_arb_n.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/mux_arb_pkg.sv
// Shared definitions for the mux_arb_n multiplexer/arbiter: mode encodings
// and the helper that sizes select and channel-ID fields.
package mux_arb_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    // Bits needed to index n channels, never less than one.
    function automatic int sel_width(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mux_arb_n_if.sv
// Bus bundle for mux_arb_n: N producer channels in, one consumer channel out.
// Handshake: a beat moves on a channel in any cycle where valid and ready are
// both high; a producer holds data/valid/last stable until that happens, and
// ready may depend combinationally on valid.
interface mux_arb_n_if #(
    parameter int N = 4,
    parameter int W = 8
);
    localparam int SW = mux_arb_pkg::sel_width(N);

    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [N-1:0]   in_last;
    logic           mode;
    logic [SW-1:0]  sel;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic           out_last;
    logic [SW-1:0]  out_ch;

    // Producers, consumer and control side.
    modport master (
        output in_data, in_valid, in_last, mode, sel, out_ready,
        input  in_ready, out_data, out_valid, out_last, out_ch
    );

    // The multiplexer itself.
    modport slave (
        input  in_data, in_valid, in_last, mode, sel, out_ready,
        output in_ready, out_data, out_valid, out_last, out_ch
    );

endinterface

// File: rtl/mux_arb_n_rr_arbiter.sv
// Round-robin request-to-grant logic. The search starts one past the last
// served channel and wraps; the pointer moves only when advance is strobed,
// so a stalled cycle keeps the same priority order.
module rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int SW = sel_width(N)   // derived from N; leave at default
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    input  logic [SW-1:0] adv_ch,
    output logic [N-1:0]  grant
);

    logic [SW-1:0] ptr_q;
    int            scan_idx;
    logic          found;

    // First requester after ptr_q, wrapping from N-1 back to 0.
    always_comb begin
        grant    = '0;
        found    = 1'b0;
        scan_idx = 0;
        for (int k = 1; k <= N; k++) begin
            scan_idx = (int'(ptr_q) + k) % N;
            if (!found && req[scan_idx]) begin
                grant[scan_idx] = 1'b1;
                found           = 1'b1;
            end
        end
    end

    // Pointer starts at N-1 so channel 0 is first in line after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= SW'(N - 1);
        end else if (advance) begin
            ptr_q <= adv_ch;
        end
    end

endmodule

// File: rtl/mux_arb_n.sv
// N-channel, W-bit registered multiplexer with per-channel valid/ready.
// MODE selects direct (SEL) or round-robin choice of the granted channel.
// Optional packet lock is enabled by defining MUX_ARB_PKT_LOCK_EN: once a
// channel sends a beat with LAST low, it keeps the grant until its LAST beat.
module mux_arb_n
    import mux_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic        clk,
    input  logic        rst,
    mux_arb_n_if.slave  bus
);

    localparam int SW = sel_width(N);

    logic          load;
    logic          xfer;
    logic [N-1:0]  rr_grant;
    logic [N-1:0]  direct_grant;
    logic [N-1:0]  grant;
    logic [SW-1:0] grant_ch;

    logic [W-1:0]  data_q;
    logic          valid_q;
    logic [SW-1:0] ch_q;

    // The output stage can take a new beat when empty or being drained.
    assign load = !valid_q || bus.out_ready;
    assign xfer = load && !rst && (|grant);

    assign bus.in_ready = (load && !rst) ? grant : '0;

    rr_arbiter #(.N(N), .SW(SW)) u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.in_valid),
        .advance (xfer && (bus.mode == MODE_RR)),
        .adv_ch  (grant_ch),
        .grant   (rr_grant)
    );

    // Direct mode: an out-of-range SEL grants nobody.
    always_comb begin
        direct_grant = '0;
        if (int'(bus.sel) < N) begin
            direct_grant[bus.sel] = bus.in_valid[bus.sel];
        end
    end

    // One-hot grant to channel index.
    always_comb begin
        grant_ch = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                grant_ch = SW'(i);
            end
        end
    end

`ifdef MUX_ARB_PKT_LOCK_EN
    logic          lock_q;
    logic [SW-1:0] lock_ch_q;
    logic          last_q;

    // While locked the grant is pinned to the packet owner, still gated by its valid.
    always_comb begin
        if (lock_q) begin
            grant            = '0;
            grant[lock_ch_q] = bus.in_valid[lock_ch_q];
        end else if (bus.mode == MODE_RR) begin
            grant = rr_grant;
        end else begin
            grant = direct_grant;
        end
    end

    // Lock opens on a non-final beat and closes on the owner's final beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q    <= 1'b0;
            lock_ch_q <= '0;
        end else if (xfer) begin
            lock_q    <= !bus.in_last[grant_ch];
            lock_ch_q <= grant_ch;
        end
    end

    // LAST travels with the beat through the output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b0;
        end else if (xfer) begin
            last_q <= bus.in_last[grant_ch];
        end
    end

    assign bus.out_last = last_q;
`else
    logic unused_last;

    // Per-beat arbitration, no lock state.
    always_comb begin
        if (bus.mode == MODE_RR) begin
            grant = rr_grant;
        end else begin
            grant = direct_grant;
        end
    end

    assign unused_last  = ^bus.in_last;
    assign bus.out_last = 1'b0;
`endif

    // Output register: capture on transfer, empty on an idle load, hold when stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ch_q    <= '0;
        end else if (load) begin
            valid_q <= xfer;
            if (xfer) begin
                data_q <= bus.in_data[int'(grant_ch)*W +: W];
                ch_q   <= grant_ch;
            end
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.out_ch    = ch_q;

endmodule

// File: tb/tb_mux_arb_n.sv
// Directed bench for mux_arb_n: a 4-channel instance for reset, direct,
// round-robin, backpressure and packet tests, plus a 3-channel instance for
// the out-of-range select case.
module tb_mux_arb_n;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mux_arb_n_if #(.N(4), .W(8)) b ();
    mux_arb_n_if #(.N(3), .W(8)) b3 ();

    mux_arb_n #(.N(4), .W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b.slave)
    );

    mux_arb_n #(.N(3), .W(8)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (b3.slave)
    );

    // Clock: 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        b.in_data    = '0;
        b.in_valid   = '0;
        b.in_last    = '0;
        b.mode       = 1'b0;
        b.sel        = '0;
        b.out_ready  = 1'b0;
        b3.in_data   = '0;
        b3.in_valid  = '0;
        b3.in_last   = '0;
        b3.mode      = 1'b0;
        b3.sel       = '0;
        b3.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        cyc();
        cyc();
        checks++; if (b.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", b.out_valid); end
        checks++; if (b.out_data !== 8'h00) begin errors++; $display("FAIL rst_out_data: got %h want 00", b.out_data); end
        checks++; if (b.out_ch !== 2'd0) begin errors++; $display("FAIL rst_out_ch: got %0d want 0", b.out_ch); end
        checks++; if (b.out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last: got %b want 0", b.out_last); end
        b.in_valid = 4'b1111;
        #1;
        checks++; if (b.in_ready !== 4'b0000) begin errors++; $display("FAIL rst_in_ready: got %b want 0000", b.in_ready); end
        rst = 1'b0;
        b.mode      = 1'b1;
        b.in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
        b.out_ready = 1'b1;
        #1;
        checks++; if (b.in_ready !== 4'b0001) begin errors++; $display("FAIL rst_first_grant: got %b want 0001", b.in_ready); end
        cyc();
        checks++; if (b.out_valid !== 1'b1 || b.out_ch !== 2'd0 || b.out_data !== 8'h10) begin
            errors++; $display("FAIL pre_rst_beat: valid %b ch %0d data %h want 1 0 10", b.out_valid, b.out_ch, b.out_data);
        end
        // Reset in the middle of a cycle while a beat is held.
        #2 rst = 1'b1;
        #1;
        checks++; if (b.out_valid !== 1'b0 || b.out_data !== 8'h00 || b.out_ch !== 2'd0) begin
            errors++; $display("FAIL mid_rst_outputs: valid %b data %h ch %0d want 0 00 0", b.out_valid, b.out_data, b.out_ch);
        end
        checks++; if (b.in_ready !== 4'b0000) begin errors++; $display("FAIL mid_rst_in_ready: got %b want 0000", b.in_ready); end
        #1 rst = 1'b0;
        #1;
        checks++; if (b.in_ready !== 4'b0001) begin errors++; $display("FAIL post_rst_grant: got %b want 0001", b.in_ready); end
        b.in_valid = 4'b0000;
        cyc();
    endtask

    task automatic test_direct();
        b.mode      = 1'b0;
        b.sel       = 2'd2;
        b.in_data   = {8'h00, 8'hA5, 8'h00, 8'h00};
        b.in_valid  = 4'b0100;
        b.out_ready = 1'b1;
        #1;
        checks++; if (b.in_ready !== 4'b0100) begin errors++; $display("FAIL direct_ready: got %b want 0100", b.in_ready); end
        cyc();
        checks++; if (b.out_valid !== 1'b1 || b.out_data !== 8'hA5 || b.out_ch !== 2'd2) begin
            errors++; $display("FAIL direct_beat: valid %b data %h ch %0d want 1 a5 2", b.out_valid, b.out_data, b.out_ch);
        end
        b.in_valid = 4'b1011;
        #1;
        checks++; if (b.in_ready !== 4'b0000) begin errors++; $display("FAIL direct_sel_idle: got %b want 0000", b.in_ready); end
        cyc();
        checks++; if (b.out_valid !== 1'b0) begin errors++; $display("FAIL direct_drain: got %b want 0", b.out_valid); end
        b.in_valid = 4'b0000;
    endtask

    task automatic test_rr_fair();
        b.mode      = 1'b1;
        b.in_data   = {8'h23, 8'h22, 8'h21, 8'h20};
        b.in_valid  = 4'b1111;
        b.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            checks++; if (b.out_ch !== 2'(i % 4) || b.out_data !== 8'(8'h20 + i % 4)) begin
                errors++; $display("FAIL rr_fair[%0d]: ch %0d data %h want %0d %h", i, b.out_ch, b.out_data, i % 4, 8'h20 + i % 4);
            end
        end
        b.in_valid = 4'b0000;
        cyc();
        checks++; if (b.out_valid !== 1'b0) begin errors++; $display("FAIL rr_fair_drain: got %b want 0", b.out_valid); end
    endtask

    task automatic test_rr_skip();
        int exp_ch;
        b.in_valid = 4'b1010;
        for (int i = 0; i < 6; i++) begin
            exp_ch = (i % 2 == 0) ? 1 : 3;
            cyc();
            checks++; if (b.out_valid !== 1'b1 || b.out_ch !== 2'(exp_ch)) begin
                errors++; $display("FAIL rr_skip[%0d]: valid %b ch %0d want 1 %0d", i, b.out_valid, b.out_ch, exp_ch);
            end
        end
        b.in_valid = 4'b0000;
        cyc();
    endtask

    task automatic test_back_pressure();
        b.in_valid  = 4'b1111;
        b.out_ready = 1'b1;
        cyc();
        checks++; if (b.out_ch !== 2'd0 || b.out_data !== 8'h20) begin
            errors++; $display("FAIL bp_first: ch %0d data %h want 0 20", b.out_ch, b.out_data);
        end
        b.out_ready = 1'b0;
        #1;
        checks++; if (b.in_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready: got %b want 0000", b.in_ready); end
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++; if (b.out_valid !== 1'b1 || b.out_data !== 8'h20 || b.out_ch !== 2'd0 || b.in_ready !== 4'b0000) begin
                errors++; $display("FAIL bp_hold[%0d]: valid %b data %h ch %0d ready %b want 1 20 0 0000",
                                   i, b.out_valid, b.out_data, b.out_ch, b.in_ready);
            end
        end
        b.out_ready = 1'b1;
        #1;
        checks++; if (b.in_ready !== 4'b0010) begin errors++; $display("FAIL bp_resume_grant: got %b want 0010", b.in_ready); end
        cyc();
        checks++; if (b.out_ch !== 2'd1 || b.out_data !== 8'h21) begin
            errors++; $display("FAIL bp_resume_beat: ch %0d data %h want 1 21", b.out_ch, b.out_data);
        end
        b.in_valid = 4'b0000;
        cyc();
    endtask

    task automatic test_sel_range();
        b3.mode      = 1'b0;
        b3.sel       = 2'd1;
        b3.in_data   = {8'h42, 8'h41, 8'h40};
        b3.in_valid  = 3'b111;
        b3.out_ready = 1'b1;
        #1;
        checks++; if (b3.in_ready !== 3'b010) begin errors++; $display("FAIL sel_in_range_ready: got %b want 010", b3.in_ready); end
        cyc();
        checks++; if (b3.out_valid !== 1'b1 || b3.out_ch !== 2'd1 || b3.out_data !== 8'h41) begin
            errors++; $display("FAIL sel_in_range_beat: valid %b ch %0d data %h want 1 1 41", b3.out_valid, b3.out_ch, b3.out_data);
        end
        b3.sel = 2'd3;
        #1;
        checks++; if (b3.in_ready !== 3'b000) begin errors++; $display("FAIL sel_oor_ready: got %b want 000", b3.in_ready); end
        cyc();
        checks++; if (b3.out_valid !== 1'b0) begin errors++; $display("FAIL sel_oor_drain: got %b want 0", b3.out_valid); end
        b3.in_valid = 3'b000;
    endtask

    task automatic test_pkt_lock();
        int exp_ch[4];
        int exp_last[4];
        logic ch1_last[4];
`ifdef MUX_ARB_PKT_LOCK_EN
        exp_ch   = '{1, 1, 1, 2};
        exp_last = '{0, 0, 1, 1};
`else
        exp_ch   = '{1, 2, 0, 1};
        exp_last = '{0, 0, 0, 0};
`endif
        ch1_last = '{1'b0, 1'b0, 1'b1, 1'b1};
        b.mode      = 1'b1;
        b.in_data   = {8'h33, 8'h32, 8'h31, 8'h30};
        b.in_last   = 4'b1111;
        b.out_ready = 1'b1;
        // A lone ch0 beat leaves ch1 next in round-robin order.
        b.in_valid  = 4'b0001;
        cyc();
        checks++; if (b.out_ch !== 2'd0 || b.out_data !== 8'h30) begin
            errors++; $display("FAIL pkt_setup: ch %0d data %h want 0 30", b.out_ch, b.out_data);
        end
        b.in_valid = 4'b0111;
        for (int i = 0; i < 4; i++) begin
            b.in_last = {1'b1, 1'b1, ch1_last[i], 1'b1};
            cyc();
            checks++; if (b.out_ch !== 2'(exp_ch[i]) || b.out_data !== 8'(8'h30 + exp_ch[i]) || b.out_last !== 1'(exp_last[i])) begin
                errors++; $display("FAIL pkt[%0d]: ch %0d data %h last %b want %0d %h %0d",
                                   i, b.out_ch, b.out_data, b.out_last, exp_ch[i], 8'h30 + exp_ch[i], exp_last[i]);
            end
        end
        b.in_valid = 4'b0000;
        cyc();
    endtask

    // Test sequence and summary.
    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_direct();
        test_rr_fair();
        test_rr_skip();
        test_back_pressure();
        test_sel_range();
        test_pkt_lock();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
